store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_store_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : store_buffer
// Description : Four-entry write buffer between the MEM stage and the data
//               memory. Stores are converted into big-endian word writes
//               (address, data, byte enables), queued in order and drained
//               one per acknowledge. Loads are probed against the queue.
// Ports       : clk, rst_n_i           - clock, async active-low reset
//               storeValid_i/Type_i/Addr_i/Data_i - store request
//               storeReady_o           - buffer can accept a store
//               loadValid_i/loadAddr_i - load probe
//               loadHazard_o           - load hits a buffered word
//               memReq_o/memAddr_o/memData_o/memByteEn_o, memAck_i
//                                      - data-memory write port
//               pending_o              - number of buffered stores
//               alignErr_o             - pulse for a rejected store
// Revision    : 1.0 - initial release
// ============================================================================
module store_buffer (
    input  logic        clk,
    input  logic        rst_n_i,
    input  logic        storeValid_i,
    input  logic [2:0]  storeType_i,
    input  logic [31:0] storeAddr_i,
    input  logic [31:0] storeData_i,
    output logic        storeReady_o,
    input  logic        loadValid_i,
    input  logic [31:0] loadAddr_i,
    output logic        loadHazard_o,
    output logic        memReq_o,
    output logic [31:0] memAddr_o,
    output logic [31:0] memData_o,
    output logic [3:0]  memByteEn_o,
    input  logic        memAck_i,
    output logic [2:0]  pending_o,
    output logic        alignErr_o
);

    localparam int          c_DEPTH = 4;
    localparam logic [2:0]  c_FULL  = 3'd4;
    localparam logic [0:0]  c_IDLE  = 1'b0;
    localparam logic [0:0]  c_DRAIN = 1'b1;

    logic [29:0] r_addr [c_DEPTH];
    logic [31:0] r_data [c_DEPTH];
    logic [3:0]  r_be   [c_DEPTH];
    logic [3:0]  r_valid;
    logic [1:0]  r_head;
    logic [1:0]  r_tail;
    logic [2:0]  r_count;
    logic [0:0]  r_state;
    logic [0:0]  w_stateNext;
    logic        r_alignErr;

    logic        w_legal;
    logic [31:0] w_data;
    logic [3:0]  w_byteEn;
    logic [1:0]  w_off;
    logic [4:0]  w_shift;
    logic [4:0]  w_revShift;
    logic        w_ready;
    logic        w_enq;
    logic        w_pop;
    logic        w_hazard;
    logic        w_unusedLoadLsbs;

    // Only the word address of a load matters for the collision check.
    assign w_unusedLoadLsbs = ^loadAddr_i[1:0];

    // Byte offset k and the two lane shifts used by the decoders:
    // 8k moves data toward the low lanes, 8(3-k) toward the high lanes.
    assign w_off      = storeAddr_i[1:0];
    assign w_shift    = {w_off, 3'b000};
    assign w_revShift = {~w_off, 3'b000};

    // Store formatting into a big-endian word write.
    always_comb begin
        w_legal  = 1'b0;
        w_data   = 32'h0;
        w_byteEn = 4'b0000;
        case (storeType_i)
            3'd0: begin // SB
                w_legal  = 1'b1;
                w_data   = {24'h0, storeData_i[7:0]} << w_revShift;
                w_byteEn = 4'b1000 >> w_off;
            end
            3'd1: begin // SH
                w_legal = ~w_off[0];
                if (w_off[1]) begin
                    w_data   = {16'h0, storeData_i[15:0]};
                    w_byteEn = 4'b0011;
                end else begin
                    w_data   = {storeData_i[15:0], 16'h0};
                    w_byteEn = 4'b1100;
                end
            end
            3'd2: begin // SW
                w_legal  = (w_off == 2'd0);
                w_data   = storeData_i;
                w_byteEn = 4'b1111;
            end
            3'd3: begin // SWL
                w_legal  = 1'b1;
                w_data   = storeData_i >> w_shift;
                w_byteEn = 4'b1111 >> w_off;
            end
            3'd4: begin // SWR
                w_legal  = 1'b1;
                w_data   = storeData_i << w_revShift;
                w_byteEn = 4'b1111 << ~w_off;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Readiness comes from the registered count only, so an ack arriving
    // this cycle never opens a slot combinationally.
    assign w_ready = (r_count < c_FULL);
    assign w_enq   = storeValid_i & w_ready & w_legal;
    assign w_pop   = (r_state == c_DRAIN) & memAck_i;

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_addr[i] <= 30'h0;
                r_data[i] <= 32'h0;
                r_be[i]   <= 4'b0000;
            end
            r_valid    <= 4'b0000;
            r_head     <= 2'd0;
            r_tail     <= 2'd0;
            r_count    <= 3'd0;
            r_alignErr <= 1'b0;
        end else begin
            r_alignErr <= storeValid_i & ~w_legal;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 2'd1;
            end
            if (w_enq) begin
                r_addr[r_tail]  <= storeAddr_i[31:2];
                r_data[r_tail]  <= w_data;
                r_be[r_tail]    <= w_byteEn;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 2'd1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Drain FSM: state register.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Drain FSM: next state.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_enq) begin
                    w_stateNext = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (w_pop && (r_count == 3'd1) && !w_enq) begin
                    w_stateNext = c_IDLE;
                end
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    // Load collision: the head stays visible during the cycle it is acked.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == loadAddr_i[31:2])) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign loadHazard_o = loadValid_i & w_hazard;
    assign storeReady_o = w_ready;
    assign pending_o    = r_count;
    assign alignErr_o   = r_alignErr;
    assign memReq_o     = (r_state == c_DRAIN);
    assign memAddr_o    = memReq_o ? {r_addr[r_head], 2'b00} : 32'h0;
    assign memData_o    = memReq_o ? r_data[r_head] : 32'h0;
    assign memByteEn_o  = memReq_o ? r_be[r_head] : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_buffer
// Description : Self-checking bench for store_buffer. A queue-based model
//               holds the buffered writes; stores are formatted lane by lane
//               from the big-endian byte rules. Directed cases pin the model
//               with literal values, then a randomized phase runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        storeValid_i;
    logic [2:0]  storeType_i;
    logic [31:0] storeAddr_i;
    logic [31:0] storeData_i;
    logic        storeReady_o;
    logic        loadValid_i;
    logic [31:0] loadAddr_i;
    logic        loadHazard_o;
    logic        memReq_o;
    logic [31:0] memAddr_o;
    logic [31:0] memData_o;
    logic [3:0]  memByteEn_o;
    logic        memAck_i;
    logic [2:0]  pending_o;
    logic        alignErr_o;

    always #5 clk = ~clk;

    store_buffer u_dut (
        .clk          (clk),
        .rst_n_i      (rst_n_i),
        .storeValid_i (storeValid_i),
        .storeType_i  (storeType_i),
        .storeAddr_i  (storeAddr_i),
        .storeData_i  (storeData_i),
        .storeReady_o (storeReady_o),
        .loadValid_i  (loadValid_i),
        .loadAddr_i   (loadAddr_i),
        .loadHazard_o (loadHazard_o),
        .memReq_o     (memReq_o),
        .memAddr_o    (memAddr_o),
        .memData_o    (memData_o),
        .memByteEn_o  (memByteEn_o),
        .memAck_i     (memAck_i),
        .pending_o    (pending_o),
        .alignErr_o   (alignErr_o)
    );

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    logic expAlign;
    int   nCompared   = 0;
    int   nMismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane j holds bits [31-8j:24-8j]; rt byte b is rt[31-8b:24-8b].
    function automatic void encode(input logic [2:0] t, input logic [31:0] a,
                                   input logic [31:0] rt, output bit legal,
                                   output logic [31:0] d, output logic [3:0] be);
        logic [7:0] rb [4];
        logic [7:0] ln [4];
        bit         en [4];
        int         k;
        k     = int'(a[1:0]);
        legal = 1'b1;
        for (int j = 0; j < 4; j++) begin
            rb[j] = rt[31-8*j -: 8];
            ln[j] = 8'h0;
            en[j] = 1'b0;
        end
        case (t)
            3'd0: begin ln[k] = rb[3]; en[k] = 1'b1; end
            3'd1: begin
                if (k % 2 != 0) legal = 1'b0;
                else begin
                    ln[k] = rb[2]; ln[k+1] = rb[3];
                    en[k] = 1'b1;  en[k+1] = 1'b1;
                end
            end
            3'd2: begin
                if (k != 0) legal = 1'b0;
                else for (int j = 0; j < 4; j++) begin ln[j] = rb[j]; en[j] = 1'b1; end
            end
            3'd3: for (int j = k; j < 4; j++) begin ln[j] = rb[j-k]; en[j] = 1'b1; end
            3'd4: for (int j = 0; j <= k; j++) begin ln[j] = rb[j+3-k]; en[j] = 1'b1; end
            default: legal = 1'b0;
        endcase
        d  = 32'h0;
        be = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            d[31-8*j -: 8] = ln[j];
            be[3-j]        = en[j];
        end
    endfunction

    // Compare every DUT output against the model for the present inputs.
    task automatic compareAll();
        bit hz;
        hz = 1'b0;
        foreach (q[i]) if (q[i].a == loadAddr_i[31:2]) hz = 1'b1;
        chk("pending",    32'(pending_o),    32'(q.size()));
        chk("storeReady", 32'(storeReady_o), 32'(q.size() < 4));
        chk("memReq",     32'(memReq_o),     32'(q.size() > 0));
        chk("alignErr",   32'(alignErr_o),   32'(expAlign));
        chk("loadHazard", 32'(loadHazard_o), 32'(loadValid_i & hz));
        if (q.size() > 0) begin
            chk("memAddr",   memAddr_o,          {q[0].a, 2'b00});
            chk("memData",   memData_o,          q[0].d);
            chk("memByteEn", 32'(memByteEn_o),   32'(q[0].be));
        end
    endtask

    // One clock: drive at negedge, check, then apply the edge to the model.
    task automatic cycle(input logic sv, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] d, input logic lv, input logic [31:0] la,
                         input logic ack);
        bit          legal;
        bit          acc;
        bit          pop;
        ent_t        e;
        @(negedge clk);
        storeValid_i = sv; storeType_i = t; storeAddr_i = a; storeData_i = d;
        loadValid_i  = lv; loadAddr_i  = la; memAck_i = ack;
        #1 compareAll();
        encode(t, a, d, legal, e.d, e.be);
        e.a = a[31:2];
        acc = sv && legal && (q.size() < 4);
        pop = ack && (q.size() > 0);
        @(posedge clk);
        expAlign = sv && !legal;
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic ack);
        cycle(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0, ack);
    endtask

    // Asynchronous reset in the middle of a cycle, released at a negedge.
    task automatic asyncReset();
        @(negedge clk);
        storeValid_i = 1'b0; memAck_i = 1'b0;
        #2 rst_n_i = 1'b0;
        #1;
        q.delete();
        expAlign = 1'b0;
        chk("rst memReq",  32'(memReq_o),  32'h0);
        chk("rst pending", 32'(pending_o), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        storeValid_i = 1'b0; storeType_i = 3'd0; storeAddr_i = 32'h0; storeData_i = 32'h0;
        loadValid_i = 1'b0; loadAddr_i = 32'h0; memAck_i = 1'b0;
        expAlign = 1'b0;
        #3;
        chk("reset pending",    32'(pending_o),    32'h0);
        chk("reset storeReady", 32'(storeReady_o), 32'h1);
        chk("reset memReq",     32'(memReq_o),     32'h0);
        chk("reset alignErr",   32'(alignErr_o),   32'h0);
        chk("reset memAddr",    memAddr_o,         32'h0);
        chk("reset memData",    memData_o,         32'h0);
        chk("reset memByteEn",  32'(memByteEn_o),  32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n_i = 1'b1;

        // SB at both ends of a word.
        cycle(1, 3'd0, 32'h00001003, 32'h000000AB, 0, 0, 0);
        chk("SB3 addr", memAddr_o, 32'h00001000);
        chk("SB3 data", memData_o, 32'h000000AB);
        chk("SB3 be",   32'(memByteEn_o), 32'h1);
        idle(1);
        chk("SB3 drained", 32'(memReq_o), 32'h0);
        cycle(1, 3'd0, 32'h00001000, 32'h000000AB, 0, 0, 0);
        chk("SB0 data", memData_o, 32'hAB000000);
        chk("SB0 be",   32'(memByteEn_o), 32'h8);
        idle(1);

        // SH at offset 2, then a misaligned SW.
        cycle(1, 3'd1, 32'h00002002, 32'h00001234, 0, 0, 0);
        chk("SH2 data", memData_o, 32'h00001234);
        chk("SH2 be",   32'(memByteEn_o), 32'h3);
        idle(1);
        cycle(1, 3'd2, 32'h00002001, 32'h11111111, 0, 0, 0);
        chk("SWmis alignErr", 32'(alignErr_o), 32'h1);
        chk("SWmis pending",  32'(pending_o),  32'h0);
        chk("SWmis memReq",   32'(memReq_o),   32'h0);
        idle(0);
        chk("alignErr one cycle", 32'(alignErr_o), 32'h0);

        // SWL, then SWR enqueued in the same cycle the SWL is acked.
        cycle(1, 3'd3, 32'h00003001, 32'hAABBCCDD, 0, 0, 0);
        chk("SWL data", memData_o, 32'h00AABBCC);
        chk("SWL be",   32'(memByteEn_o), 32'h7);
        cycle(1, 3'd4, 32'h00003001, 32'hAABBCCDD, 0, 0, 1);
        chk("SWR pending", 32'(pending_o), 32'h1);
        chk("SWR data", memData_o, 32'hCCDD0000);
        chk("SWR be",   32'(memByteEn_o), 32'hC);
        idle(1);

        // Fill to capacity; the fifth store is refused.
        for (int i = 0; i < 5; i++)
            cycle(1, 3'd2, 32'h100 + 32'(4*i), 32'(i+1), 0, 0, 0);
        chk("full pending", 32'(pending_o), 32'h4);
        chk("full ready",   32'(storeReady_o), 32'h0);
        chk("full head",    memAddr_o, 32'h00000100);
        idle(1);
        chk("after ack ready", 32'(storeReady_o), 32'h1);
        chk("after ack head",  memAddr_o, 32'h00000104);
        chk("after ack data",  memData_o, 32'h00000002);
        repeat (3) idle(1);
        chk("drained", 32'(pending_o), 32'h0);

        // Load hazard probes.
        cycle(1, 3'd2, 32'h00001000, 32'h5A5A5A5A, 0, 0, 0);
        loadValid_i = 1'b1; loadAddr_i = 32'h00001002;
        #1 chk("hazard same word", 32'(loadHazard_o), 32'h1);
        loadAddr_i = 32'h00001004;
        #1 chk("hazard next word", 32'(loadHazard_o), 32'h0);
        loadValid_i = 1'b0; loadAddr_i = 32'h00001002;
        #1 chk("hazard no load", 32'(loadHazard_o), 32'h0);
        idle(1);

        // Reset in the middle of a drain discards everything.
        for (int i = 0; i < 3; i++)
            cycle(1, 3'd2, 32'h200 + 32'(4*i), 32'hC0DE0000 + 32'(i), 0, 0, 0);
        chk("pre-reset pending", 32'(pending_o), 32'h3);
        asyncReset();
        repeat (4) idle(1);

        // Randomized phase.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] t;
            if (n % 700 == 699) asyncReset();
            t = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            cycle(1'($urandom_range(0, 9) < 6), t,
                  32'h00001000 + 32'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 32'h00001000 + 32'($urandom_range(0, 19)),
                  1'($urandom_range(0, 9) < 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
